// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: accumulator sequencer driving an external 4-bit ALU, with LOAD and shift-and-add MUL.
module alu_seq_ctrl #(
    parameter int          DATA_W      = 4,
    parameter logic [3:0]  IDLE_SELECT = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [3:0]        alu_select,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_c_out,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              done,
    output logic              err,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    state_t state, state_next;
    logic [3:0] op;
    logic [DATA_W-1:0] opr, m, p;
    logic [1:0] step;
    logic o, o_next, accept;
    logic [2*DATA_W-1:0] mshift;
    assign cmd_ready = state == IDLE;
    assign busy = ~cmd_ready;
    assign accept = cmd_valid && cmd_ready;
    assign mshift = {{DATA_W{1'b0}}, m} << step;
    // product overflows if a used partial loses bits or the running sum carries out
    assign o_next = o | (opr[step] & (alu_c_out | (|mshift[2*DATA_W-1:DATA_W])));

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        alu_x = acc;
        alu_y = '0;
        alu_select = IDLE_SELECT;
        case (state)
            IDLE: if (accept) state_next = (cmd_op == 4'hD) ? MUL : EXEC;
            EXEC: begin
                state_next = IDLE;
                if (op < 4'hC) begin
                    alu_y = opr;
                    alu_select = op;
                end
            end
            MUL: begin
                alu_x = p;
                alu_y = opr[step] ? mshift[DATA_W-1:0] : '0;
                alu_select = 4'h2;
                if (step == 2'd3) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            acc <= '0;
            carry <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            op <= '0;
            opr <= '0;
            m <= '0;
            p <= '0;
            o <= 1'b0;
            step <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op <= cmd_op;
                opr <= cmd_data;
                m <= acc;
                p <= '0;
                o <= 1'b0;
                step <= '0;
            end
            if (state == EXEC) begin
                done <= 1'b1;
                err <= &op[3:1];
                if (op < 4'hC) begin
                    acc <= alu_out;
                    carry <= ~op[3] & alu_c_out;
                end else if (op == 4'hC) begin
                    acc <= opr;
                    carry <= 1'b0;
                end
            end
            if (state == MUL) begin
                p <= alu_out;
                o <= o_next;
                step <= step + 2'd1;
                if (step == 2'd3) begin
                    acc <= alu_out;
                    carry <= o_next;
                    done <= 1'b1;
                    err <= 1'b0;
                end
            end
        end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table vectors, corner sequences and random commands against an arithmetic model.
module tb_alu_seq_ctrl;
    logic clk = 0, reset = 1, cmd_valid = 0, cmd_ready, alu_c_out, carry, done, err, busy;
    logic [3:0] cmd_op = 0, cmd_data = 0, alu_x, alu_y, alu_select, alu_out, acc;
    int tests = 0, fails = 0;
    logic [3:0] acc_m = 0;
    logic carry_m = 0, err_m = 0;

    alu_seq_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .alu_x(alu_x), .alu_y(alu_y),
        .alu_select(alu_select), .alu_out(alu_out), .alu_c_out(alu_c_out),
        .acc(acc), .carry(carry), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // external ALU stand-in; subtract-style ops report carry = no borrow
    function automatic logic [4:0] alu_f(input logic [3:0] x, input logic [3:0] y, input logic [3:0] s);
        case (s)
            4'h0: return {1'b0, x};
            4'h1: return {1'b0, x} + 5'd1;
            4'h2: return {1'b0, x} + {1'b0, y};
            4'h3: return {1'b0, x} + {1'b0, y} + 5'd1;
            4'h4: return {1'b0, x} + 5'h0F;
            4'h5: return {1'b0, x} + {1'b0, ~y} + 5'd1;
            4'h6: return {1'b0, y} + {1'b0, ~x} + 5'd1;
            4'h7: return {x, 1'b0};
            4'h8: return {1'b0, x & y};
            4'h9: return {1'b0, x | y};
            4'hA: return {1'b0, x ^ y};
            4'hB: return {1'b0, ~x};
            default: return 5'h0;
        endcase
    endfunction

    always_comb {alu_c_out, alu_out} = alu_f(alu_x, alu_y, alu_select);

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [3:0] op, input logic [3:0] d);
        logic [4:0] r;
        int prod;
        if (op <= 4'hB) begin
            r = alu_f(acc_m, d, op);
            acc_m = r[3:0];
            carry_m = op < 4'h8 ? r[4] : 1'b0;
            err_m = 0;
        end else if (op == 4'hC) begin
            acc_m = d; carry_m = 0; err_m = 0;
        end else if (op == 4'hD) begin
            prod = int'(acc_m) * int'(d);
            acc_m = 4'(prod % 16); carry_m = prod >= 16; err_m = 0;
        end else err_m = 1;
    endtask

    // called at a negedge in IDLE; returns at a negedge one cycle after done
    task automatic run_cmd(input logic [3:0] op, input logic [3:0] d);
        int n;
        chk("ready_before", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op; cmd_data = d;
        @(negedge clk);
        cmd_valid = 0; cmd_data = 4'($urandom);
        if (op <= 4'hB) begin
            chk("exec_select", alu_select, op);
            chk("exec_y", alu_y, d);
        end else if (op != 4'hD) chk("exec_idle_select", alu_select, 0);
        chk("busy_during", busy, 1);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, op == 4'hD ? 5 : 2);
        model(op, d);
        chk("acc", acc, acc_m);
        chk("carry", carry, carry_m);
        chk("err", err, err_m);
        chk("ready_with_done", cmd_ready, 1);
        @(negedge clk);
        chk("done_width", done, 0);
    endtask

    typedef struct {
        logic [3:0] op, data, acc;
        logic carry, err;
    } vec_t;

    vec_t vecs[11];
    int dn;

    initial begin
        vecs = '{
            '{4'hC, 4'h9, 4'h9, 1'b0, 1'b0}, '{4'h2, 4'h8, 4'h1, 1'b1, 1'b0},
            '{4'h5, 4'h3, 4'hE, 1'b0, 1'b0}, '{4'hC, 4'h3, 4'h3, 1'b0, 1'b0},
            '{4'hD, 4'h5, 4'hF, 1'b0, 1'b0}, '{4'hC, 4'h6, 4'h6, 1'b0, 1'b0},
            '{4'hD, 4'h7, 4'hA, 1'b1, 1'b0}, '{4'hC, 4'h5, 4'h5, 1'b0, 1'b0},
            '{4'hB, 4'h0, 4'hA, 1'b0, 1'b0}, '{4'hE, 4'h7, 4'hA, 1'b0, 1'b1},
            '{4'hC, 4'h2, 4'h2, 1'b0, 1'b0}
        };
        #1;
        chk("rst_acc", acc, 0); chk("rst_carry", carry, 0); chk("rst_done", done, 0);
        chk("rst_err", err, 0); chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0);
        @(negedge clk); @(negedge clk);
        reset = 0;
        @(negedge clk);
        foreach (vecs[i]) begin
            run_cmd(vecs[i].op, vecs[i].data);
            chk($sformatf("vec%0d_acc", i), acc, vecs[i].acc);
            chk($sformatf("vec%0d_carry", i), carry, vecs[i].carry);
            chk($sformatf("vec%0d_err", i), err, vecs[i].err);
        end
        // cmd_valid held high: two MULs accepted back to back, never more
        cmd_valid = 1; cmd_op = 4'hD; cmd_data = 4'h3;
        dn = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 2) chk("held_busy", busy, 1);
            if (done) begin
                dn++;
                model(4'hD, 4'h3);
                chk("held_acc", acc, acc_m);
                chk("held_carry", carry, carry_m);
                chk("held_ready", cmd_ready, 1);
                chk("held_done_cycle", n, dn * 5);
            end
        end
        cmd_valid = 0;
        chk("held_done_count", dn, 2);
        chk("held_final_acc", acc, 4'h2);
        chk("held_final_carry", carry, 1);
        @(negedge clk); @(negedge clk);
        // reset during MUL step 2
        run_cmd(4'hC, 4'h7);
        cmd_valid = 1; cmd_op = 4'hD; cmd_data = 4'h7;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk); @(negedge clk);
        reset = 1;
        #1;
        chk("mrst_acc", acc, 0); chk("mrst_carry", carry, 0);
        chk("mrst_busy", busy, 0); chk("mrst_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 0;
        dn = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("mrst_no_done", dn, 0);
        chk("mrst_acc_after", acc, 0);
        acc_m = 0; carry_m = 0; err_m = 0;
        for (int i = 0; i < 40; i++) run_cmd(4'($urandom_range(0, 15)), 4'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
